// File: rtl/ysyx_23060184_lsu.sv
// ============================================================================
// Module      : ysyx_23060184_lsu
// Description : Load/store unit with one data-memory transaction at a time
//               over valid/ready request and response channels.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_23060184_lsu #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_wen,
    input  logic [2:0]              in_funct3,
    input  logic [DATA_WIDTH-1:0]   in_addr,
    input  logic [DATA_WIDTH-1:0]   in_wdata,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic                    mem_req_wen,
    output logic [DATA_WIDTH-1:0]   mem_req_addr,
    output logic [DATA_WIDTH-1:0]   mem_req_wdata,
    output logic [3:0]              mem_req_wstrb,
    input  logic                    mem_rsp_valid,
    output logic                    mem_rsp_ready,
    input  logic [DATA_WIDTH-1:0]   mem_rsp_rdata,
    input  logic                    mem_rsp_err,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   ReadData,
    output logic [1:0]              out_fault
);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_REQ      = 2'd1;
    localparam logic [1:0] c_WAIT_RSP = 2'd2;
    localparam logic [1:0] c_DONE     = 2'd3;

    localparam logic [1:0] c_FAULT_OK       = 2'b00;
    localparam logic [1:0] c_FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] c_FAULT_BUS      = 2'b10;
    localparam logic [1:0] c_FAULT_ILLEGAL  = 2'b11;

    logic [1:0]            r_state;
    logic                  r_wen;
    logic [2:0]            r_funct3;
    logic [DATA_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [3:0]            r_wstrb;
    logic [DATA_WIDTH-1:0] r_readData;
    logic [1:0]            r_fault;

    logic                  w_illegal;
    logic                  w_misaligned;
    logic [1:0]            w_off;
    logic [3:0]            w_strb;
    logic [DATA_WIDTH-1:0] w_wdataShift;
    logic [DATA_WIDTH-1:0] w_shifted;
    logic [DATA_WIDTH-1:0] w_loadData;
    logic                  w_inReq;

    // Accept-time decode of the incoming op; results are registered before use.
    always_comb begin
        w_off        = in_addr[1:0];
        w_illegal    = 1'b0;
        w_misaligned = 1'b0;
        w_strb       = 4'b0000;
        w_wdataShift = in_wdata << {w_off, 3'b000};
        if (in_wen) begin
            w_illegal = in_funct3[2] | (in_funct3[1:0] == 2'b11);
        end else begin
            w_illegal = (in_funct3 == 3'b011) | (in_funct3 == 3'b110) | (in_funct3 == 3'b111);
        end
        case (in_funct3[1:0])
            2'b01:   w_misaligned = in_addr[0];
            2'b10:   w_misaligned = (in_addr[1:0] != 2'b00);
            default: w_misaligned = 1'b0;
        endcase
        case (in_funct3[1:0])
            2'b00:   w_strb = 4'b0001 << w_off;
            2'b01:   w_strb = 4'b0011 << w_off;
            default: w_strb = 4'b1111;
        endcase
    end

    always_comb begin
        w_shifted  = mem_rsp_rdata >> {r_addr[1:0], 3'b000};
        w_loadData = w_shifted;
        case (r_funct3)
            3'b000:  w_loadData = {{(DATA_WIDTH-8){w_shifted[7]}}, w_shifted[7:0]};
            3'b100:  w_loadData = {{(DATA_WIDTH-8){1'b0}}, w_shifted[7:0]};
            3'b001:  w_loadData = {{(DATA_WIDTH-16){w_shifted[15]}}, w_shifted[15:0]};
            3'b101:  w_loadData = {{(DATA_WIDTH-16){1'b0}}, w_shifted[15:0]};
            default: w_loadData = w_shifted;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_wen      <= 1'b0;
            r_funct3   <= 3'b000;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wstrb    <= 4'b0000;
            r_readData <= '0;
            r_fault    <= c_FAULT_OK;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_wen      <= in_wen;
                        r_funct3   <= in_funct3;
                        r_addr     <= in_addr;
                        r_wdata    <= w_wdataShift;
                        r_wstrb    <= in_wen ? w_strb : 4'b0000;
                        r_readData <= '0;
                        if (w_illegal) begin
                            r_fault <= c_FAULT_ILLEGAL;
                            r_state <= c_DONE;
                        end else if (w_misaligned) begin
                            r_fault <= c_FAULT_MISALIGN;
                            r_state <= c_DONE;
                        end else begin
                            r_fault <= c_FAULT_OK;
                            r_state <= c_REQ;
                        end
                    end
                end
                c_REQ: begin
                    if (mem_req_ready) begin
                        r_state <= c_WAIT_RSP;
                    end
                end
                c_WAIT_RSP: begin
                    if (mem_rsp_valid) begin
                        if (mem_rsp_err) begin
                            r_fault    <= c_FAULT_BUS;
                            r_readData <= '0;
                        end else begin
                            r_fault    <= c_FAULT_OK;
                            r_readData <= r_wen ? '0 : w_loadData;
                        end
                        r_state <= c_DONE;
                    end
                end
                c_DONE: begin
                    if (out_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Request fields read as zero outside REQ so idle/reset values are clean.
    assign w_inReq       = (r_state == c_REQ);
    assign in_ready      = (r_state == c_IDLE);
    assign mem_req_valid = w_inReq;
    assign mem_req_wen   = w_inReq & r_wen;
    assign mem_req_addr  = w_inReq ? {r_addr[DATA_WIDTH-1:2], 2'b00} : '0;
    assign mem_req_wdata = (w_inReq & r_wen) ? r_wdata : '0;
    assign mem_req_wstrb = w_inReq ? r_wstrb : 4'b0000;
    assign mem_rsp_ready = (r_state == c_WAIT_RSP);
    assign out_valid     = (r_state == c_DONE);
    assign ReadData      = r_readData;
    assign out_fault     = r_fault;

endmodule

`default_nettype wire
